// File: rtl/hdd_sd_bridge.sv
// Bridges the IIgs hard-disk port (channel 0) to the HPS SD block interface,
// with request latching, mount/protect rejection and a watchdog on lost acks.
module hdd_sd_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 14_318_180
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        hdd_read,
  input  logic        hdd_write,
  input  logic [15:0] hdd_sector,
  input  logic        img_mounted,
  input  logic        img_readonly,
  input  logic [63:0] img_size,
  input  logic        sd_ack,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic        cpu_wait,
  output logic        hdd_mounted,
  output logic        hdd_protect,
  output logic        hdd_done,
  output logic        hdd_error
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [23:0] TO_LAST = 24'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state;
  logic        pend_valid;
  logic        pend_write;
  logic [15:0] pend_sector;
  logic        old_ack;
  logic        ack_block;
  logic [23:0] to_cnt;
  logic        mounted_r = 1'b0;
  logic        protect_r = 1'b0;

  logic ack_rise;
  logic ack_fall;
  logic timed_out;
  logic can_accept;
  logic reject;

  always_comb begin
    ack_rise   = sd_ack & ~old_ack;
    ack_fall   = ~sd_ack & old_ack;
    timed_out  = (to_cnt == TO_LAST);
    can_accept = pend_valid & ~(ack_block & sd_ack);
    reject     = ~mounted_r | (pend_write & protect_r);
  end

  // Mount state deliberately ignores reset so an image survives a warm reset.
  always_ff @(posedge clk_sys) begin
    if (img_mounted) begin
      mounted_r <= (img_size != 64'd0);
      protect_r <= img_readonly;
    end
  end

  assign hdd_mounted = mounted_r;
  assign hdd_protect = protect_r;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= ST_IDLE;
      pend_valid  <= 1'b0;
      pend_write  <= 1'b0;
      pend_sector <= '0;
      old_ack     <= 1'b0;
      ack_block   <= 1'b0;
      to_cnt      <= '0;
      sd_lba      <= '0;
      sd_rd       <= 1'b0;
      sd_wr       <= 1'b0;
      cpu_wait    <= 1'b0;
      hdd_done    <= 1'b0;
      hdd_error   <= 1'b0;
    end else begin
      old_ack  <= sd_ack;
      hdd_done <= 1'b0;
      if (ack_block && !sd_ack)
        ack_block <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (can_accept) begin
            pend_valid <= 1'b0;
            hdd_error  <= 1'b0;
            if (reject) begin
              hdd_error <= 1'b1;
              state     <= ST_DONE;
            end else begin
              sd_lba   <= {16'h0000, pend_sector};
              sd_rd    <= ~pend_write;
              sd_wr    <= pend_write;
              cpu_wait <= 1'b1;
              to_cnt   <= '0;
              state    <= ST_REQ;
            end
          end
        end
        ST_REQ, ST_XFER: begin
          if (timed_out) begin
            // Abort holds off new requests until the HPS side releases sd_ack.
            sd_rd     <= 1'b0;
            sd_wr     <= 1'b0;
            hdd_error <= 1'b1;
            ack_block <= 1'b1;
            state     <= ST_DONE;
          end else begin
            to_cnt <= to_cnt + 24'd1;
            if (state == ST_REQ && ack_rise) begin
              sd_rd <= 1'b0;
              sd_wr <= 1'b0;
              state <= ST_XFER;
            end else if (state == ST_XFER && ack_fall) begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          hdd_done <= 1'b1;
          cpu_wait <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // A fresh pulse overrides consumption in the same cycle; read beats write.
      if (hdd_read || hdd_write) begin
        pend_valid  <= 1'b1;
        pend_write  <= ~hdd_read;
        pend_sector <= hdd_sector;
      end
    end
  end

endmodule

// File: tb/tb_hdd_sd_bridge.sv
// Directed self-checking bench for hdd_sd_bridge; a second instance with a
// short watchdog covers the timeout path.
module tb_hdd_sd_bridge;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        hdd_read, hdd_write, img_mounted, img_readonly, sd_ack;
  logic [15:0] hdd_sector;
  logic [63:0] img_size;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, cpu_wait, hdd_mounted, hdd_protect, hdd_done, hdd_error;

  logic        t_read, t_write, t_img_mounted, t_img_readonly, t_ack;
  logic [15:0] t_sector;
  logic [63:0] t_img_size;
  logic [31:0] t_sd_lba;
  logic        t_sd_rd, t_sd_wr, t_cpu_wait, t_mounted, t_protect, t_done, t_error;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_sys = ~clk_sys;

  hdd_sd_bridge dut (
    .clk_sys(clk_sys), .reset(reset), .hdd_read(hdd_read), .hdd_write(hdd_write),
    .hdd_sector(hdd_sector), .img_mounted(img_mounted), .img_readonly(img_readonly),
    .img_size(img_size), .sd_ack(sd_ack), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .cpu_wait(cpu_wait), .hdd_mounted(hdd_mounted), .hdd_protect(hdd_protect),
    .hdd_done(hdd_done), .hdd_error(hdd_error)
  );

  hdd_sd_bridge #(.TIMEOUT_CYCLES(100)) dut_to (
    .clk_sys(clk_sys), .reset(reset), .hdd_read(t_read), .hdd_write(t_write),
    .hdd_sector(t_sector), .img_mounted(t_img_mounted), .img_readonly(t_img_readonly),
    .img_size(t_img_size), .sd_ack(t_ack), .sd_lba(t_sd_lba), .sd_rd(t_sd_rd), .sd_wr(t_sd_wr),
    .cpu_wait(t_cpu_wait), .hdd_mounted(t_mounted), .hdd_protect(t_protect),
    .hdd_done(t_done), .hdd_error(t_error)
  );

  // Stimulus helpers: each starts and ends just after a falling edge.
  task automatic mount(input logic ro, input logic [63:0] size);
    img_mounted = 1'b1; img_readonly = ro; img_size = size;
    @(negedge clk_sys);
    img_mounted = 1'b0;
  endtask

  task automatic pulse_req(input logic rd, input logic wr, input logic [15:0] sec);
    hdd_read = rd; hdd_write = wr; hdd_sector = sec;
    @(negedge clk_sys);
    hdd_read = 1'b0; hdd_write = 1'b0;
  endtask

  task automatic ack_cycle(input int hold);
    sd_ack = 1'b1;
    repeat (hold) @(negedge clk_sys);
    sd_ack = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 0; i < 30; i++) begin
      if (hdd_done === 1'b1) begin
        cyc = i;
        break;
      end
      @(negedge clk_sys);
    end
  endtask

  task automatic test_reset();
    @(negedge clk_sys);
    n_cmp++; if (sd_rd !== 1'b0 || sd_wr !== 1'b0) begin n_bad++; $display("FAIL reset_strobes: rd=%b wr=%b expected 0 0", sd_rd, sd_wr); end
    n_cmp++; if (cpu_wait !== 1'b0 || hdd_done !== 1'b0 || hdd_error !== 1'b0) begin n_bad++; $display("FAIL reset_status: wait=%b done=%b err=%b expected 0 0 0", cpu_wait, hdd_done, hdd_error); end
    n_cmp++; if (sd_lba !== 32'h0) begin n_bad++; $display("FAIL reset_lba: got %h expected 00000000", sd_lba); end
    n_cmp++; if (hdd_mounted !== 1'b0 || hdd_protect !== 1'b0) begin n_bad++; $display("FAIL powerup_mount: mounted=%b protect=%b expected 0 0", hdd_mounted, hdd_protect); end
    n_cmp++; if (t_sd_rd !== 1'b0 || t_cpu_wait !== 1'b0) begin n_bad++; $display("FAIL reset_to_inst: rd=%b wait=%b expected 0 0", t_sd_rd, t_cpu_wait); end
    reset = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic test_read();
    mount(1'b0, 64'd33554432);
    n_cmp++; if (hdd_mounted !== 1'b1 || hdd_protect !== 1'b0) begin n_bad++; $display("FAIL mount_rw: mounted=%b protect=%b expected 1 0", hdd_mounted, hdd_protect); end
    pulse_req(1'b1, 1'b0, 16'h0123);
    @(negedge clk_sys);
    n_cmp++; if (sd_lba !== 32'h00000123) begin n_bad++; $display("FAIL read_lba: got %h expected 00000123", sd_lba); end
    n_cmp++; if (sd_rd !== 1'b1 || sd_wr !== 1'b0 || cpu_wait !== 1'b1) begin n_bad++; $display("FAIL read_issue: rd=%b wr=%b wait=%b expected 1 0 1", sd_rd, sd_wr, cpu_wait); end
    sd_ack = 1'b1;
    @(negedge clk_sys);
    n_cmp++; if (sd_rd !== 1'b0 || cpu_wait !== 1'b1) begin n_bad++; $display("FAIL read_ack_rise: rd=%b wait=%b expected 0 1", sd_rd, cpu_wait); end
    repeat (511) @(negedge clk_sys);
    sd_ack = 1'b0;
    @(negedge clk_sys);
    n_cmp++; if (hdd_done !== 1'b0 || cpu_wait !== 1'b1) begin n_bad++; $display("FAIL read_pre_done: done=%b wait=%b expected 0 1", hdd_done, cpu_wait); end
    @(negedge clk_sys);
    n_cmp++; if (hdd_done !== 1'b1 || cpu_wait !== 1'b0 || hdd_error !== 1'b0) begin n_bad++; $display("FAIL read_done: done=%b wait=%b err=%b expected 1 0 0", hdd_done, cpu_wait, hdd_error); end
    @(negedge clk_sys);
    n_cmp++; if (hdd_done !== 1'b0) begin n_bad++; $display("FAIL read_done_pulse: done=%b expected 0", hdd_done); end
  endtask

  task automatic test_protect();
    int cyc;
    mount(1'b1, 64'd33554432);
    n_cmp++; if (hdd_protect !== 1'b1) begin n_bad++; $display("FAIL mount_ro: protect=%b expected 1", hdd_protect); end
    pulse_req(1'b0, 1'b1, 16'h0005);
    @(negedge clk_sys);
    n_cmp++; if (hdd_error !== 1'b1 || sd_wr !== 1'b0 || cpu_wait !== 1'b0 || hdd_done !== 1'b0) begin n_bad++; $display("FAIL wp_reject: err=%b wr=%b wait=%b done=%b expected 1 0 0 0", hdd_error, sd_wr, cpu_wait, hdd_done); end
    @(negedge clk_sys);
    n_cmp++; if (hdd_done !== 1'b1 || hdd_error !== 1'b1 || sd_wr !== 1'b0 || cpu_wait !== 1'b0) begin n_bad++; $display("FAIL wp_done: done=%b err=%b wr=%b wait=%b expected 1 1 0 0", hdd_done, hdd_error, sd_wr, cpu_wait); end
    pulse_req(1'b1, 1'b0, 16'h0042);
    @(negedge clk_sys);
    n_cmp++; if (sd_rd !== 1'b1 || hdd_error !== 1'b0 || sd_lba !== 32'h42) begin n_bad++; $display("FAIL wp_read_ok: rd=%b err=%b lba=%h expected 1 0 00000042", sd_rd, hdd_error, sd_lba); end
    ack_cycle(3);
    wait_done(cyc);
    n_cmp++; if (cyc != 2 || hdd_error !== 1'b0) begin n_bad++; $display("FAIL wp_read_done: cycles=%0d err=%b expected 2 0", cyc, hdd_error); end
    @(negedge clk_sys);
  endtask

  task automatic test_unmounted();
    mount(1'b0, 64'd0);
    n_cmp++; if (hdd_mounted !== 1'b0) begin n_bad++; $display("FAIL mount_zero: mounted=%b expected 0", hdd_mounted); end
    pulse_req(1'b1, 1'b0, 16'h0001);
    @(negedge clk_sys);
    n_cmp++; if (hdd_error !== 1'b1 || cpu_wait !== 1'b0 || sd_rd !== 1'b0) begin n_bad++; $display("FAIL nomount_reject: err=%b wait=%b rd=%b expected 1 0 0", hdd_error, cpu_wait, sd_rd); end
    @(negedge clk_sys);
    n_cmp++; if (hdd_done !== 1'b1 || cpu_wait !== 1'b0) begin n_bad++; $display("FAIL nomount_done: done=%b wait=%b expected 1 0", hdd_done, cpu_wait); end
    @(negedge clk_sys);
  endtask

  task automatic test_timeout();
    t_img_mounted = 1'b1; t_img_size = 64'd1048576;
    @(negedge clk_sys);
    t_img_mounted = 1'b0;
    t_read = 1'b1; t_sector = 16'h0abc;
    @(negedge clk_sys);
    t_read = 1'b0;
    @(negedge clk_sys);
    n_cmp++; if (t_sd_rd !== 1'b1 || t_cpu_wait !== 1'b1) begin n_bad++; $display("FAIL to_issue: rd=%b wait=%b expected 1 1", t_sd_rd, t_cpu_wait); end
    repeat (99) @(negedge clk_sys);
    n_cmp++; if (t_sd_rd !== 1'b1 || t_error !== 1'b0) begin n_bad++; $display("FAIL to_early: rd=%b err=%b expected 1 0", t_sd_rd, t_error); end
    @(negedge clk_sys);
    n_cmp++; if (t_sd_rd !== 1'b0 || t_error !== 1'b1 || t_done !== 1'b0) begin n_bad++; $display("FAIL to_abort: rd=%b err=%b done=%b expected 0 1 0", t_sd_rd, t_error, t_done); end
    // Late ack from the abandoned transfer arrives together with a new request.
    t_ack = 1'b1; t_read = 1'b1; t_sector = 16'h0def;
    @(negedge clk_sys);
    t_read = 1'b0;
    n_cmp++; if (t_done !== 1'b1 || t_cpu_wait !== 1'b0) begin n_bad++; $display("FAIL to_done: done=%b wait=%b expected 1 0", t_done, t_cpu_wait); end
    repeat (3) @(negedge clk_sys);
    n_cmp++; if (t_sd_rd !== 1'b0 || t_cpu_wait !== 1'b0) begin n_bad++; $display("FAIL to_block: rd=%b wait=%b expected 0 0", t_sd_rd, t_cpu_wait); end
    t_ack = 1'b0;
    @(negedge clk_sys);
    n_cmp++; if (t_sd_rd !== 1'b1 || t_sd_lba !== 32'h0def) begin n_bad++; $display("FAIL to_resume: rd=%b lba=%h expected 1 00000def", t_sd_rd, t_sd_lba); end
    t_ack = 1'b1;
    repeat (2) @(negedge clk_sys);
    t_ack = 1'b0;
    repeat (3) @(negedge clk_sys);
    n_cmp++; if (t_error !== 1'b0 || t_cpu_wait !== 1'b0) begin n_bad++; $display("FAIL to_recover: err=%b wait=%b expected 0 0", t_error, t_cpu_wait); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    mount(1'b0, 64'd33554432);
    pulse_req(1'b1, 1'b0, 16'h0010);
    @(negedge clk_sys);
    n_cmp++; if (sd_rd !== 1'b1) begin n_bad++; $display("FAIL b2b_read: rd=%b expected 1", sd_rd); end
    pulse_req(1'b0, 1'b1, 16'h0007);
    pulse_req(1'b0, 1'b1, 16'h0009);
    ack_cycle(4);
    @(negedge clk_sys);
    @(negedge clk_sys);
    n_cmp++; if (hdd_done !== 1'b1 || sd_wr !== 1'b0) begin n_bad++; $display("FAIL b2b_read_done: done=%b wr=%b expected 1 0", hdd_done, sd_wr); end
    @(negedge clk_sys);
    n_cmp++; if (sd_wr !== 1'b1 || sd_lba !== 32'h9 || cpu_wait !== 1'b1) begin n_bad++; $display("FAIL b2b_write: wr=%b lba=%h wait=%b expected 1 00000009 1", sd_wr, sd_lba, cpu_wait); end
    ack_cycle(2);
    wait_done(cyc);
    n_cmp++; if (cyc != 2) begin n_bad++; $display("FAIL b2b_write_done: cycles=%0d expected 2", cyc); end
    repeat (5) @(negedge clk_sys);
    n_cmp++; if (sd_wr !== 1'b0 || sd_rd !== 1'b0 || cpu_wait !== 1'b0) begin n_bad++; $display("FAIL b2b_single_write: wr=%b rd=%b wait=%b expected 0 0 0", sd_wr, sd_rd, cpu_wait); end
    pulse_req(1'b1, 1'b1, 16'h0055);
    @(negedge clk_sys);
    n_cmp++; if (sd_rd !== 1'b1 || sd_wr !== 1'b0 || sd_lba !== 32'h55) begin n_bad++; $display("FAIL both_read_wins: rd=%b wr=%b lba=%h expected 1 0 00000055", sd_rd, sd_wr, sd_lba); end
    ack_cycle(2);
    wait_done(cyc);
    repeat (5) @(negedge clk_sys);
    n_cmp++; if (cyc != 2 || sd_wr !== 1'b0 || cpu_wait !== 1'b0) begin n_bad++; $display("FAIL both_no_write: cycles=%0d wr=%b wait=%b expected 2 0 0", cyc, sd_wr, cpu_wait); end
  endtask

  task automatic test_reset_mid_xfer();
    logic seen;
    pulse_req(1'b1, 1'b0, 16'h0077);
    @(negedge clk_sys);
    sd_ack = 1'b1;
    repeat (3) @(negedge clk_sys);
    reset = 1'b1;
    @(negedge clk_sys);
    n_cmp++; if (sd_rd !== 1'b0 || cpu_wait !== 1'b0 || sd_lba !== 32'h0) begin n_bad++; $display("FAIL rst_xfer: rd=%b wait=%b lba=%h expected 0 0 00000000", sd_rd, cpu_wait, sd_lba); end
    n_cmp++; if (hdd_mounted !== 1'b1) begin n_bad++; $display("FAIL rst_keep_mount: mounted=%b expected 1", hdd_mounted); end
    reset = 1'b0;
    @(negedge clk_sys);
    sd_ack = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_sys);
      seen = seen | hdd_done | cpu_wait;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rst_stale_ack: done/wait seen=%b expected 0", seen); end
  endtask

  initial begin
    reset = 1'b1;
    hdd_read = 1'b0; hdd_write = 1'b0; hdd_sector = '0;
    img_mounted = 1'b0; img_readonly = 1'b0; img_size = '0; sd_ack = 1'b0;
    t_read = 1'b0; t_write = 1'b0; t_sector = '0;
    t_img_mounted = 1'b0; t_img_readonly = 1'b0; t_img_size = '0; t_ack = 1'b0;
    repeat (2) @(negedge clk_sys);
    test_reset();
    test_read();
    test_protect();
    test_unmounted();
    test_timeout();
    test_back_to_back();
    test_reset_mid_xfer();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hdd_sd_bridge.md
# hdd_sd_bridge

Bridges the IIgs core's hard-disk port (channel 0) to the HPS SD block interface. It accepts single-cycle read/write sector requests from the `iigs` HDD port and issues the `sd_rd`/`sd_wr`/`sd_ack` handshake towards `hps_io` slot 0. It stalls the CPU through `cpu_wait` while a transfer is in flight, and tracks image mount and write-protect state. It adds request latching, protection/mount rejection and a watchdog timeout, so a lost `sd_ack` can never hang the CPU.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 14_318_180: cycles allowed in REQ+XFER before abort (1 s at 14.318 MHz); must fit in 24 bits.

Ports:
- `clk_sys`  in  1  system clock (14.318 MHz).
- `reset`  in  1  synchronous, active-high reset.
- `hdd_read`  in  1  one-cycle read request pulse.
- `hdd_write`  in  1  one-cycle write request pulse.
- `hdd_sector`  in  16  sector number, sampled with the request pulse.
- `img_mounted`  in  1  one-cycle pulse: image (re)mounted on slot 0.
- `img_readonly`  in  1  image read-only flag, valid with `img_mounted`.
- `img_size`  in  64  image size in bytes, valid with `img_mounted`.
- `sd_ack`  in  1  HPS transfer acknowledge (high for the whole buffer transfer).
- `sd_lba`  out  32  `{16'b0, latched sector}`.
- `sd_rd`  out  1  read strobe to HPS.
- `sd_wr`  out  1  write strobe to HPS.
- `cpu_wait`  out  1  stalls the CPU while a request is outstanding.
- `hdd_mounted`  out  1  image present (`img_size != 0`).
- `hdd_protect`  out  1  image is read-only.
- `hdd_done`  out  1  one-cycle pulse at end of every request (success, reject or timeout).
- `hdd_error`  out  1  status of last request; sticky until the next request is accepted.

## Operation
- All outputs are registered. Reset values: `sd_rd`, `sd_wr`, `cpu_wait`, `hdd_done`, `hdd_error` = 0. `sd_lba` = 0. State = IDLE, pending slot cleared, timeout counter 0.
- `hdd_mounted`/`hdd_protect` are NOT cleared by `reset`. They power up 0 and update only on `img_mounted`, so images survive warm reset.
- Pending slot: `{valid, is_write, sector}`. A request pulse in any state loads the slot.
  - Simultaneous `hdd_read` and `hdd_write`: the read is loaded and the write is dropped.
  - A new pulse while the slot is valid overwrites it (last wins).
- IDLE, slot valid: consume the slot and clear `hdd_error`, then branch:
  - Not mounted, or write while `hdd_protect`: go to DONE with `hdd_error` set to 1. No `sd_rd`/`sd_wr` is issued.
  - Otherwise: latch `sd_lba`, assert `sd_rd` or `sd_wr` and `cpu_wait`, clear the counter, go to REQ.
- REQ: on the `sd_ack` rising edge (registered `old_ack` compare), drop `sd_rd`/`sd_wr` and go to XFER.
- XFER: on the `sd_ack` falling edge, go to DONE.
- DONE: pulse `hdd_done` for one cycle, drop `cpu_wait`, go to IDLE.
- Timeout: the counter increments every cycle in REQ/XFER. When it reaches `TIMEOUT_CYCLES-1`:
  - Drop `sd_rd`/`sd_wr`, set `hdd_error`, go to DONE.
  - The next request is not accepted until `sd_ack` is low.
- `img_mounted` during REQ/XFER updates the mount flags but does not abort the transfer in progress.

## Timing
- Request pulse at edge N → slot valid at N+1 → `sd_rd`/`sd_wr` and `cpu_wait` high at N+2.
- `sd_ack` high sampled at edge A → `sd_rd`/`sd_wr` low at A+1.
- `sd_ack` low sampled at edge B → DONE at B+1 (`hdd_done` = 1, `cpu_wait` = 0 at B+2).
- Rejected request: `hdd_done` and `hdd_error` high 2 cycles after the slot becomes valid. `cpu_wait` never rises.
- Back-to-back: a slot loaded during a transfer starts REQ 1 cycle after DONE.
- `reset` high at any edge: outputs take their reset values at that edge. An in-flight HPS transfer is abandoned and its late `sd_ack` is ignored (no edge is recorded while in IDLE).

## Test plan
- Mount 32 MB read-write image, pulse `hdd_read` with sector 0x0123 → `sd_lba` = 0x00000123, `sd_rd` = 1, `cpu_wait` = 1. Drive ack high for 512 cycles → `sd_rd` falls 1 cycle after ack rises. `hdd_done` fires, `cpu_wait` = 0, `hdd_error` = 0.
- Mount read-only image, pulse `hdd_write` → `sd_wr` never asserts, `hdd_done` = 1 and `hdd_error` = 1. A following read succeeds and clears `hdd_error`.
- No image mounted, pulse `hdd_read` → rejected with `hdd_error` = 1 and `cpu_wait` staying 0. Mount with `img_size` = 0 → `hdd_mounted` stays 0.
- `TIMEOUT_CYCLES` = 100, read with no ack → at cycle 100 `sd_rd` = 0, `hdd_error` = 1, `hdd_done` pulses, `cpu_wait` = 0.
- During a read transfer, pulse `hdd_write` with sector 7, then `hdd_write` with sector 9 → after the read completes, one write with `sd_lba` = 9 is issued. Simultaneous read+write pulse → only the read is issued.
- Assert `reset` mid-XFER → `sd_rd`/`cpu_wait` = 0 next cycle and `hdd_mounted` retained. Stale ack fall produces no `hdd_done`.
